bram_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly upstream of the dual-port blockram `bramd` and drives its ports.
- Writes go through RAM port A. Reads go through RAM port B, and the registered read data returns through `ram_doutb`.
- It converts the RAM's 2-cycle registered read latency into a first-word-fall-through valid/ready stream, using a 3-entry output queue and read credits.
- Used as the generic buffered stream FIFO on MAX 10 builds.

---
 rtl/bram_fifo_ctrl.sv | 150 +++++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: first-word-fall-through stream FIFO built around an external
// dual-port block RAM. Port A takes pushes, port B issues reads whose registered
// data returns two edges later; a 3-entry output queue plus read credits turns
// that latency into a plain valid/ready stream.
module bram_fifo_ctrl #(
   parameter int ADDR_ = 8,
   parameter int DATA_ = 8
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATA_-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATA_-1:0] out_data,
   output logic [ADDR_+1:0] count,
   output logic             ram_wea,
   output logic [ADDR_-1:0] ram_addra,
   output logic [DATA_-1:0] ram_dina,
   output logic             ram_web,
   output logic [ADDR_-1:0] ram_addrb,
   output logic [DATA_-1:0] ram_dinb,
   input  logic [DATA_-1:0] ram_doutb
);

   localparam int PTR_W  = ADDR_ + 1;
   localparam int CNT_W  = ADDR_ + 2;
   localparam int QDEPTH = 3;

   // RAM occupancy value meaning "every RAM word holds unread data".
   localparam logic [PTR_W-1:0] RAM_FULL = {1'b1, {ADDR_{1'b0}}};

   // Pointers carry one extra MSB so full and empty differ.
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] ram_cnt;

   // Read-valid shift pipe: bit 0 = address presented, bit 1 = ram_doutb valid.
   logic [1:0]       pipe_q, pipe_d;

   // Output queue; entry 0 is the head and drives out_data directly.
   logic [1:0]       q_cnt_q, q_cnt_d;
   logic [DATA_-1:0] q_data_q [QDEPTH];
   logic [DATA_-1:0] q_data_d [QDEPTH];
   logic             out_valid_q, out_valid_d;

   logic [CNT_W-1:0] count_q, count_d;

   logic             push;
   logic             pop;
   logic             capture;
   logic             rd_issue;
   logic [1:0]       q_keep;
   logic [2:0]       credits_used;

   // Handshakes, occupancy and read-credit decision for the current cycle.
   always_comb begin
      ram_cnt  = wr_ptr_q - rd_ptr_q;
      in_ready = ~aclr & (ram_cnt != RAM_FULL);
      push     = in_valid & in_ready;
      pop      = out_valid_q & out_ready;
      capture  = pipe_q[1];
      // Queue entries that survive this edge; the head leaving now frees its
      // slot for a same-cycle issue, which is what sustains one word per cycle.
      q_keep       = q_cnt_q - {1'b0, pop};
      credits_used = {1'b0, q_keep} + {2'b00, pipe_q[0]} + {2'b00, pipe_q[1]};
      // Registered pointers only: a word written at this edge is readable next cycle,
      // which avoids the RAM's mixed-port read-during-write behaviour.
      rd_issue = (ram_cnt != '0) & (credits_used < 3'd3);
   end

   // Next-state for pointers, read pipe, output queue and word count.
   always_comb begin
      // NOTE: every target gets its hold value first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      pipe_d   = pipe_q;
      q_data_d = q_data_q;
      q_cnt_d  = q_cnt_q;
      count_d  = count_q;

      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_issue);
      pipe_d   = {pipe_q[0], rd_issue};

      if (pop) begin
         for (int i = 0; i < QDEPTH - 1; i++) begin
            q_data_d[i] = q_data_q[i + 1];
         end
      end

      // Returning word lands right behind whatever survives this edge.
      if (capture) begin
         case (q_keep)
            2'd0:    q_data_d[0] = ram_doutb;
            2'd1:    q_data_d[1] = ram_doutb;
            2'd2:    q_data_d[2] = ram_doutb;
            default: q_data_d[0] = q_data_q[0];
         endcase
      end

      q_cnt_d     = q_keep + {1'b0, capture};
      out_valid_d = (q_cnt_d != 2'd0);
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // State registers; reset discards stored words and any reads still in flight.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pipe_q      <= '0;
         q_cnt_q     <= '0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
         // NOTE: the queue is only three words, so it is reset outright; entry 0
         // is out_data, which must come up 0.
         for (int i = 0; i < QDEPTH; i++) begin
            q_data_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pipe_q      <= pipe_d;
         q_cnt_q     <= q_cnt_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
         for (int i = 0; i < QDEPTH; i++) begin
            q_data_q[i] <= q_data_d[i];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = q_data_q[0];
   assign count     = count_q;

   // Port A: writes only.
   assign ram_wea   = push;
   assign ram_addra = wr_ptr_q[ADDR_-1:0];
   assign ram_dina  = in_data;

   // Port B: reads only.
   assign ram_web   = 1'b0;
   assign ram_addrb = rd_ptr_q[ADDR_-1:0];
   assign ram_dinb  = '0;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Testbench for bram_fifo_ctrl: behavioural FIFO model (word queue with push
// edge stamps) checked every cycle, plus directed literal expectations.
`timescale 1ns/100ps
module tb_bram_fifo_ctrl;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              aclr;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W+1:0] count;
   logic              ram_wea;
   logic [ADDR_W-1:0] ram_addra;
   logic [DATA_W-1:0] ram_dina;
   logic              ram_web;
   logic [ADDR_W-1:0] ram_addrb;
   logic [DATA_W-1:0] ram_dinb;
   logic [DATA_W-1:0] ram_doutb;

   int checks   = 0;
   int failures = 0;

   bram_fifo_ctrl #(.ADDR_(ADDR_W), .DATA_(DATA_W)) dut (
      .clk       (clk),
      .aclr      (aclr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .ram_wea   (ram_wea),
      .ram_addra (ram_addra),
      .ram_dina  (ram_dina),
      .ram_web   (ram_web),
      .ram_addrb (ram_addrb),
      .ram_dinb  (ram_dinb),
      .ram_doutb (ram_doutb)
   );

   always #5 clk = ~clk;

   // Block RAM stand-in: address registered on one edge, data on the next.
   logic [DATA_W-1:0] ram_mem [DEPTH];
   logic [ADDR_W-1:0] ram_addr_r;
   always @(posedge clk) begin
      if (ram_wea) ram_mem[ram_addra] <= ram_dina;
      ram_addr_r <= ram_addrb;
      ram_doutb  <= ram_mem[ram_addr_r];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state: words held, the edge each was pushed at, pushes since reset.
   logic [DATA_W-1:0] m_q [$];
   int unsigned       m_e [$];
   int unsigned       m_wr   = 0;
   int unsigned       edge_n = 0;   // index of the most recent rising edge
   logic [DATA_W-1:0] got_q [$];    // every popped word, in order
   int unsigned       got_e [$];    // edge index just before each pop edge

   // Model compare at every falling edge, then apply this cycle's handshakes.
   initial begin
      bit exp_v;
      forever begin
         @(negedge clk);
         if (aclr) begin
            m_q.delete();
            m_e.delete();
            m_wr = 0;
         end else begin
            check("model_count", 32'(count), m_q.size());
            exp_v = (m_q.size() != 0) && (edge_n >= m_e[0] + 3);
            check("model_out_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) check("model_out_data", 32'(out_data), 32'(m_q[0]));
            if (m_q.size() <= DEPTH - 1) check("model_in_ready_room", 32'(in_ready), 1);
            if (m_q.size() == DEPTH + 3) check("model_in_ready_full", 32'(in_ready), 0);
            check("model_ram_wea", 32'(ram_wea), 32'(in_valid & in_ready));
            if (ram_wea) begin
               check("model_ram_addra", 32'(ram_addra), m_wr % DEPTH);
               check("model_ram_dina", 32'(ram_dina), 32'(in_data));
            end
            check("model_ram_web", 32'(ram_web), 0);
            check("model_ram_dinb", 32'(ram_dinb), 0);
            if (out_valid && out_ready) begin
               got_q.push_back(out_data);
               got_e.push_back(edge_n);
               if (m_q.size() != 0) begin
                  void'(m_q.pop_front());
                  void'(m_e.pop_front());
               end
            end
            if (in_valid && in_ready) begin
               m_q.push_back(in_data);
               m_e.push_back(edge_n + 1);
               m_wr++;
            end
         end
         edge_n++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word for one cycle; acc reports whether it was taken.
   task automatic drive_push(input logic [DATA_W-1:0] d, output bit acc);
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      aclr      = 1'b1;
      #3 aclr   = 1'b0;
      step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      bit          acc;
      int          base, acc_n, guard, bad, mx;
      int unsigned e0;
      logic [7:0]  d;

      aclr      = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      #12 aclr  = 1'b0;
      step();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_count", 32'(count), 0);
      check("rst_in_ready", 32'(in_ready), 1);

      // 1: asynchronous reset mid-cycle with a push being offered.
      drive_push(8'h31, acc);
      drive_push(8'h32, acc);
      check("t1_count_before", 32'(count), 2);
      in_data  = 8'h77;
      in_valid = 1'b1;
      #2 aclr  = 1'b1;
      #1;
      check("t1_async_count", 32'(count), 0);
      check("t1_async_out_valid", 32'(out_valid), 0);
      check("t1_no_wea", 32'(ram_wea), 0);
      #2;
      in_valid = 1'b0;
      aclr     = 1'b0;
      #0.5;
      check("t1_in_ready_release", 32'(in_ready), 1);
      check("t1_count_release", 32'(count), 0);
      step();

      // 2: single word, latency and stall.
      drive_push(8'hA5, acc);
      in_valid = 1'b0;
      check("t2_accepted", 32'(acc), 1);
      check("t2_count_e0", 32'(count), 1);
      check("t2_ov_e0", 32'(out_valid), 0);
      step();
      check("t2_ov_e1", 32'(out_valid), 0);
      step();
      check("t2_ov_e2", 32'(out_valid), 0);
      step();
      check("t2_ov_e3", 32'(out_valid), 1);
      check("t2_od_e3", 32'(out_data), 32'h A5);
      step();
      check("t2_od_stall", 32'(out_data), 32'h A5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t2_ov_after_pop", 32'(out_valid), 0);
      check("t2_count_after_pop", 32'(count), 0);

      // 3: fill to capacity, then drain in order.
      do_reset();
      base  = got_q.size();
      acc_n = 0;
      d     = 8'h00;
      for (int i = 0; i < 24; i++) begin
         drive_push(d, acc);
         if (acc) begin
            acc_n++;
            d++;
         end
      end
      check("t3_accepted", acc_n, 19);
      check("t3_count_full", 32'(count), 19);
      check("t3_in_ready_full", 32'(in_ready), 0);
      check("t3_head", 32'(out_data), 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("t3_in_ready_pre_pop", 32'(in_ready), 0);
      step();
      check("t3_in_ready_post_pop", 32'(in_ready), 1);
      guard = 0;
      while (got_q.size() - base < 19 && guard < 60) begin
         step();
         guard++;
      end
      out_ready = 1'b0;
      check("t3_drained", got_q.size() - base, 19);
      bad = -1;
      for (int i = 0; i < 19 && base + i < got_q.size(); i++) begin
         if (bad < 0 && got_q[base + i] !== 8'(i)) bad = i;
      end
      check("t3_order_first_bad", bad, -1);
      step();
      check("t3_count_empty", 32'(count), 0);

      // 4: back-to-back streaming across the RAM address wrap.
      do_reset();
      base      = got_q.size();
      out_ready = 1'b1;
      acc_n     = 0;
      guard     = 0;
      mx        = 0;
      e0        = 0;
      while (acc_n < 40 && guard < 80) begin
         in_data  = 8'(acc_n);
         in_valid = 1'b1;
         @(negedge clk);
         acc = in_ready;
         if (acc && acc_n == 15) check("t4_addra_15", 32'(ram_addra), 15);
         if (acc && acc_n == 16) check("t4_addra_wrap", 32'(ram_addra), 0);
         if (int'(count) > mx) mx = int'(count);
         @(posedge clk);
         #1;
         if (acc) begin
            if (acc_n == 0) e0 = edge_n;
            acc_n++;
         end
         guard++;
      end
      in_valid = 1'b0;
      guard    = 0;
      while (got_q.size() - base < 40 && guard < 20) begin
         @(negedge clk);
         if (int'(count) > mx) mx = int'(count);
         @(posedge clk);
         #1;
         guard++;
      end
      check("t4_accepted", acc_n, 40);
      check("t4_received", got_q.size() - base, 40);
      bad = -1;
      for (int i = 0; i < 40 && base + i < got_q.size(); i++) begin
         if (bad < 0 && got_q[base + i] !== 8'(i)) bad = i;
      end
      check("t4_order_first_bad", bad, -1);
      if (got_q.size() - base == 40) begin
         check("t4_first_latency", got_e[base] - e0, 3);
         check("t4_no_bubbles", got_e[base + 39] - got_e[base], 39);
      end
      check("t4_count_le_4", 32'(mx <= 4), 1);
      out_ready = 1'b0;

      // 5: random backpressure with a continuous incrementing push.
      do_reset();
      base = got_q.size();
      d    = 8'h00;
      acc_n = 0;
      for (int i = 0; i < 300; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         drive_push(d, acc);
         if (acc) begin
            d++;
            acc_n++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard     = 0;
      while (m_q.size() != 0 && guard < 100) begin
         step();
         guard++;
      end
      step();
      out_ready = 1'b0;
      check("t5_all_out", got_q.size() - base, acc_n);
      bad = -1;
      for (int i = 0; base + i < got_q.size(); i++) begin
         if (bad < 0 && got_q[base + i] !== 8'(i)) bad = i;
      end
      check("t5_order_first_bad", bad, -1);
      check("t5_count_empty", 32'(count), 0);

      // 6: reset while two reads are in flight; stale RAM data must be ignored.
      do_reset();
      drive_push(8'hC0, acc);
      drive_push(8'hC1, acc);
      drive_push(8'hC2, acc);
      in_valid = 1'b0;
      #2 aclr  = 1'b1;
      #1;
      check("t6_async_count", 32'(count), 0);
      check("t6_async_out_valid", 32'(out_valid), 0);
      #2 aclr  = 1'b0;
      step();
      check("t6_ov_stale", 32'(out_valid), 0);
      drive_push(8'h5A, acc);
      in_valid = 1'b0;
      check("t6_accepted", 32'(acc), 1);
      check("t6_ov_e0", 32'(out_valid), 0);
      step();
      check("t6_ov_e1", 32'(out_valid), 0);
      step();
      check("t6_ov_e2", 32'(out_valid), 0);
      step();
      check("t6_ov_e3", 32'(out_valid), 1);
      check("t6_od_e3", 32'(out_data), 32'h5A);
      check("t6_count_e3", 32'(count), 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t6_ov_after_pop", 32'(out_valid), 0);
      check("t6_count_after_pop", 32'(count), 0);

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
